// File: rtl/dlx_mem_arbiter_if.sv
// Bus bundle between the DLX requesters, the memory arbiter and the shared memory port.
// The arbiter uses the master modport; requesters plus memory form the slave side.
interface dlx_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NUM_CH = 2
);
    logic [NUM_CH-1:0]        ch_enable;
    logic [NUM_CH-1:0]        ch_rnw;
    logic [NUM_CH*ADDR_W-1:0] ch_addr;
    logic [NUM_CH*DATA_W-1:0] ch_wdata;
    logic [NUM_CH-1:0]        ch_ready;
    logic [DATA_W-1:0]        ch_rdata;
    logic                     mem_enable;
    logic                     mem_rnw;
    logic [ADDR_W-1:0]        mem_addr;
    logic [DATA_W-1:0]        mem_wdata;
    logic [DATA_W-1:0]        mem_rdata;
    logic                     mem_ready;

    modport master (
        input  ch_enable, ch_rnw, ch_addr, ch_wdata, mem_rdata, mem_ready,
        output ch_ready, ch_rdata, mem_enable, mem_rnw, mem_addr, mem_wdata
    );

    modport slave (
        output ch_enable, ch_rnw, ch_addr, ch_wdata, mem_rdata, mem_ready,
        input  ch_ready, ch_rdata, mem_enable, mem_rnw, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dlx_mem_arbiter.sv
// Round-robin N-channel arbiter onto one registered memory port, one transaction in flight.
// Optional BUSY-cycle abort is compiled in with the ARB_TIMEOUT_EN macro.
module dlx_mem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int NUM_CH         = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    dlx_mem_arbiter_if.master         bus,
    output logic [$clog2(NUM_CH)-1:0] grant_id,
    output logic                      busy,
    output logic                      timeout_err
);
    localparam int GNT_W = $clog2(NUM_CH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]       state;
    logic [GNT_W-1:0] last_grant;
    logic [GNT_W-1:0] winner;
    logic [GNT_W-1:0] idx;
    logic             found;
    logic             abort;

    // Search starts one past the previous winner so every held request is reached within NUM_CH grants.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = last_grant;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (idx == GNT_W'(NUM_CH - 1)) ? '0 : idx + GNT_W'(1);
            if (!found && bus.ch_enable[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt;

    // The limit is reached on the edge ending the last allowed BUSY cycle; mem_ready on that cycle still wins.
    assign abort = (state == ST_BUSY) && !bus.mem_ready &&
                   (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= abort;
            if (state != ST_BUSY) begin
                tmo_cnt <= '0;
            end else if (!bus.mem_ready) begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
        end
    end
`else
    assign abort       = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            last_grant     <= GNT_W'(NUM_CH - 1);
            grant_id       <= '0;
            busy           <= 1'b0;
            bus.mem_enable <= 1'b0;
            bus.mem_rnw    <= 1'b1;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            bus.ch_ready   <= '0;
            bus.ch_rdata   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        bus.mem_enable <= 1'b1;
                        bus.mem_rnw    <= bus.ch_rnw[winner];
                        bus.mem_addr   <= bus.ch_addr[int'(winner)*ADDR_W +: ADDR_W];
                        bus.mem_wdata  <= bus.ch_wdata[int'(winner)*DATA_W +: DATA_W];
                        grant_id       <= winner;
                        last_grant     <= winner;
                        busy           <= 1'b1;
                        state          <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // mem_* stay frozen here; only completion or abort moves the FSM on.
                    if (bus.mem_ready) begin
                        bus.mem_enable <= 1'b0;
                        bus.ch_ready   <= NUM_CH'(1) << grant_id;
                        if (bus.mem_rnw) begin
                            bus.ch_rdata <= bus.mem_rdata;
                        end
                        state <= ST_RESP;
                    end else if (abort) begin
                        bus.mem_enable <= 1'b0;
                        bus.ch_ready   <= NUM_CH'(1) << grant_id;
                        bus.ch_rdata   <= {DATA_W{1'b1}};
                        state          <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    bus.ch_ready <= '0;
                    busy         <= 1'b0;
                    state        <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dlx_mem_arbiter.sv
// Scoreboard bench for dlx_mem_arbiter: directed corner cases followed by randomized request rounds.
// Expected transactions come from a round-robin/memory model and are checked by an independent monitor.
module tb_dlx_mem_arbiter;
    localparam int NCH = 3;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 8;

    typedef struct {
        int            ch;
        bit            rnw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        bit            tmo;
    } txn_t;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [$clog2(NCH)-1:0] grant_id;
    logic                   busy;
    logic                   timeout_err;

    dlx_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_CH(NCH)) bus ();

    dlx_mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_CH(NCH), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    txn_t          expq[$];
    int            n_cmp = 0;
    int            n_err = 0;
    int            model_last = NCH - 1;
    logic [DW-1:0] model_rdata = '0;
    int            ws_cfg = -1;
    bit            hang = 1'b0;
    int            wait_left = 0;
    bit            in_txn = 1'b0;
    bit            en_prev = 1'b0;
    bit            acc_prev = 1'b0;
    logic [AW+DW:0] cap;
    txn_t          mon_t;
    int            ef, ec, ra, nrdy;
    logic [NCH-1:0] rset, rearly;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        return 32'hA5A5_0000 ^ (a >> 4);
    endfunction

    // Completion order equals push order, so the write-side rdata (previous value) is known at push time.
    function automatic void push_exp(input int c, input bit rnw, input logic [AW-1:0] a,
                                     input logic [DW-1:0] wd, input bit tmo);
        txn_t t;
        t.ch = c; t.rnw = rnw; t.addr = a; t.wdata = wd; t.tmo = tmo;
        if (tmo)      t.rdata = '1;
        else if (rnw) t.rdata = mem_fn(a);
        else          t.rdata = model_rdata;
        model_rdata = t.rdata;
        model_last  = c;
        expq.push_back(t);
    endfunction

    function automatic void model_reset();
        expq.delete();
        model_last  = NCH - 1;
        model_rdata = '0;
    endfunction

    task automatic drive_req(input int c, input bit rnw, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        bus.ch_enable[c]           = 1'b1;
        bus.ch_rnw[c]              = rnw;
        bus.ch_addr[c*AW +: AW]    = a;
        bus.ch_wdata[c*DW +: DW]   = wd;
    endtask

    task automatic do_txn(input int c, input bit rnw, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input bit tmo, output int en_first, output int en_cnt, output int rdy_at);
        push_exp(c, rnw, a, wd, tmo);
        @(posedge clk); #1;
        drive_req(c, rnw, a, wd);
        en_first = -1; en_cnt = 0; rdy_at = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.mem_enable) begin
                en_cnt++;
                if (en_first < 0) en_first = i;
            end
            if (bus.ch_ready != 0) begin
                rdy_at = i;
                break;
            end
        end
        bus.ch_enable = '0;
    endtask

    task automatic wait_readies(input int k, input bit chk_period);
        int seen = 0;
        int prev = -1;
        for (int i = 0; i < 40 * k && seen < k; i++) begin
            @(negedge clk);
            if (bus.ch_ready != 0) begin
                if (chk_period && prev >= 0) check("b2b_period", 64'(i - prev), 64'd3);
                prev = i;
                seen++;
            end
        end
        if (seen < k) check("ready_count", 64'(seen), 64'(k));
    endtask

    // All channels of the set request together and hold until served; model order is the rotation after last grant.
    task automatic run_round(input logic [NCH-1:0] set, input logic [NCH-1:0] early);
        logic [NCH-1:0] pending;
        int start;
        bit rnw;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        int c;
        start = model_last;
        @(posedge clk); #1;
        for (int k = 1; k <= NCH; k++) begin
            c = (start + k) % NCH;
            if (set[c]) begin
                rnw = 1'($urandom_range(0, 1));
                a   = $urandom;
                wd  = $urandom;
                push_exp(c, rnw, a, wd, 1'b0);
                drive_req(c, rnw, a, wd);
            end
        end
        pending = set;
        for (int i = 0; i < 200 && pending != 0; i++) begin
            @(negedge clk);
            for (int j = 0; j < NCH; j++) begin
                if (bus.ch_ready[j] && pending[j]) begin
                    pending[j]       = 1'b0;
                    bus.ch_enable[j] = 1'b0;
                end
                if (early[j] && bus.mem_enable && int'(grant_id) == j) bus.ch_enable[j] = 1'b0;
            end
        end
        if (pending != 0) check("round_done", 64'(pending), 64'd0);
        bus.ch_enable = '0;
    endtask

    // Memory responder: wait states per transaction, random mem_ready noise while mem_enable is low.
    initial begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk); #2;
            if (bus.mem_enable === 1'b1 && !rst) begin
                if (!in_txn) begin
                    in_txn    = 1'b1;
                    wait_left = (ws_cfg >= 0) ? ws_cfg : int'($urandom_range(0, 3));
                end
                if (!hang && wait_left == 0) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = mem_fn(bus.mem_addr);
                    in_txn        = 1'b0;
                end else begin
                    bus.mem_ready = 1'b0;
                    bus.mem_rdata = $urandom;
                    if (wait_left > 0) wait_left--;
                end
            end else begin
                in_txn        = 1'b0;
                bus.mem_ready = hang ? 1'b0 : 1'($urandom_range(0, 1));
                bus.mem_rdata = $urandom;
            end
        end
    end

    // Monitor: checks memory-side issue against the queue head and pops it on each ch_ready pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                en_prev  = 1'b0;
                acc_prev = 1'b0;
            end else begin
                if (bus.mem_enable && !en_prev) begin
                    if (expq.size() == 0) begin
                        check("unexpected_mem_txn", 64'(bus.mem_enable), 64'd0);
                    end else begin
                        mon_t = expq[0];
                        check("grant_id", 64'(grant_id), 64'(mon_t.ch));
                        check("mem_rnw", 64'(bus.mem_rnw), 64'(mon_t.rnw));
                        check("mem_addr", 64'(bus.mem_addr), 64'(mon_t.addr));
                        if (!mon_t.rnw) check("mem_wdata", 64'(bus.mem_wdata), 64'(mon_t.wdata));
                        check("busy_in_txn", 64'(busy), 64'd1);
                    end
                    cap = {bus.mem_rnw, bus.mem_addr, bus.mem_wdata};
                end else if (bus.mem_enable) begin
                    check("mem_stable", 64'({bus.mem_rnw, bus.mem_addr, bus.mem_wdata} != cap), 64'd0);
                end
                if (bus.ch_ready != 0) begin
                    if (expq.size() == 0) begin
                        check("unexpected_ready", 64'(bus.ch_ready), 64'd0);
                    end else begin
                        mon_t = expq.pop_front();
                        check("ch_ready", 64'(bus.ch_ready), 64'd1 << mon_t.ch);
                        check("ch_rdata", 64'(bus.ch_rdata), 64'(mon_t.rdata));
                        check("ready_cause", 64'(acc_prev), 64'(!mon_t.tmo));
                        check("timeout_err", 64'(timeout_err), 64'(mon_t.tmo));
                    end
                end else begin
                    if (acc_prev) check("ready_missing", 64'(bus.ch_ready != 0), 64'd1);
                    if (timeout_err) check("stray_timeout_err", 64'(timeout_err), 64'd0);
                end
                en_prev  = bus.mem_enable;
                acc_prev = bus.mem_enable && bus.mem_ready;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.ch_enable = NCH'($urandom);
        bus.ch_rnw    = NCH'($urandom);
        for (int c = 0; c < NCH; c++) begin
            bus.ch_addr[c*AW +: AW]  = $urandom;
            bus.ch_wdata[c*DW +: DW] = $urandom;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_enable", 64'(bus.mem_enable), 64'd0);
        check("rst_mem_rnw", 64'(bus.mem_rnw), 64'd1);
        check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
        check("rst_ch_ready", 64'(bus.ch_ready), 64'd0);
        check("rst_ch_rdata", 64'(bus.ch_rdata), 64'd0);
        check("rst_grant_id", 64'(grant_id), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_timeout_err", 64'(timeout_err), 64'd0);
        @(posedge clk); #1;
        rst           = 1'b0;
        bus.ch_enable = '0;
        model_reset();

        // Contention from reset: ch0/ch1 held, expect 0,1,0,1 at one grant per 3 cycles.
        ws_cfg = 0;
        push_exp(0, 1'b1, 32'h100, 32'h0, 1'b0);
        push_exp(1, 1'b0, 32'h104, 32'hCAFE_0001, 1'b0);
        push_exp(0, 1'b1, 32'h100, 32'h0, 1'b0);
        push_exp(1, 1'b0, 32'h104, 32'hCAFE_0001, 1'b0);
        @(posedge clk); #1;
        drive_req(0, 1'b1, 32'h100, 32'h0);
        drive_req(1, 1'b0, 32'h104, 32'hCAFE_0001);
        wait_readies(4, 1'b1);
        bus.ch_enable = '0;

        do_txn(0, 1'b1, 32'h10, 32'h0, 1'b0, ef, ec, ra);
        check("rd_en_latency", 64'(ef), 64'd1);
        check("rd_en_cycles", 64'(ec), 64'd1);
        check("rd_ready_latency", 64'(ra), 64'd2);
        check("rd_data", 64'(bus.ch_rdata), 64'hA5A5_0001);

        ws_cfg = 3;
        do_txn(1, 1'b0, 32'h200, 32'h1234_5678, 1'b0, ef, ec, ra);
        check("wr_en_cycles", 64'(ec), 64'd4);
        check("wr_ready_latency", 64'(ra), 64'd5);
        check("wr_rdata_kept", 64'(bus.ch_rdata), 64'hA5A5_0001);

        // Reset on the second BUSY cycle of a ch1 read.
        ws_cfg = -1;
        hang   = 1'b1;
        push_exp(1, 1'b1, 32'h300, 32'h0, 1'b0);
        @(posedge clk); #1;
        drive_req(1, 1'b1, 32'h300, 32'h0);
        @(negedge clk);
        @(negedge clk);
        check("abort_busy", 64'(bus.mem_enable), 64'd1);
        @(posedge clk); #1;
        rst           = 1'b1;
        bus.ch_enable = '0;
        model_reset();
        @(posedge clk); #1;
        rst  = 1'b0;
        hang = 1'b0;
        @(negedge clk);
        check("abort_mem_enable", 64'(bus.mem_enable), 64'd0);
        check("abort_ch_ready", 64'(bus.ch_ready), 64'd0);
        check("abort_busy_low", 64'(busy), 64'd0);
        run_round(3'b011, 3'b000);

`ifdef ARB_TIMEOUT_EN
        hang = 1'b1;
        do_txn(0, 1'b1, 32'h400, 32'h0, 1'b1, ef, ec, ra);
        check("tmo_en_cycles", 64'(ec), 64'(TMO));
        check("tmo_ready_latency", 64'(ra), 64'(TMO + 1));
        check("tmo_rdata", 64'(bus.ch_rdata), 64'hFFFF_FFFF);
        check("tmo_err", 64'(timeout_err), 64'd1);
        @(negedge clk);
        check("tmo_err_pulse", 64'(timeout_err), 64'd0);
        hang   = 1'b0;
        ws_cfg = TMO - 1;
        do_txn(0, 1'b1, 32'h404, 32'h0, 1'b0, ef, ec, ra);
        check("limit_ready_latency", 64'(ra), 64'(TMO + 1));
        check("limit_no_err", 64'(timeout_err), 64'd0);
`else
        hang = 1'b1;
        nrdy = 0;
        push_exp(0, 1'b1, 32'h400, 32'h0, 1'b0);
        @(posedge clk); #1;
        drive_req(0, 1'b1, 32'h400, 32'h0);
        repeat (101) begin
            @(negedge clk);
            if (bus.ch_ready != 0) nrdy++;
        end
        check("hang_busy", 64'(busy), 64'd1);
        check("hang_mem_enable", 64'(bus.mem_enable), 64'd1);
        check("hang_no_ready", 64'(nrdy), 64'd0);
        check("hang_no_err", 64'(timeout_err), 64'd0);
        @(posedge clk); #1;
        rst           = 1'b1;
        bus.ch_enable = '0;
        model_reset();
        @(posedge clk); #1;
        rst  = 1'b0;
        hang = 1'b0;
`endif

        ws_cfg = -1;
        for (int r = 0; r < 40; r++) begin
            rset   = NCH'($urandom_range(1, (1 << NCH) - 1));
            rearly = NCH'($urandom);
            run_round(rset, rearly);
        end

        repeat (4) @(negedge clk);
        check("queue_drained", 64'(expq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
